// File: rtl/uart_tx_framer.sv
// UART transmit framer.
// Accepts one word per txValid/txReady handshake. It holds countEnable high for the whole
// frame so the baud generator runs, and advances one bit per bpsClk pulse. Each frame is
// start, data (LSB first), optional even parity, then STOP_BITS stop bits.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit after the data.
// Every output is a register driven from the single state-machine block below.

module uart_tx_framer #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] txData,
  input  logic                 txValid,
  output logic                 txReady,
  input  logic                 bpsClk,
  output logic                 countEnable,
  output logic                 txd,
  output logic                 txDone
);

  // Counter reused for data bits and stop bits; 4 bits covers DATA_BITS up to 9.
  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] LastData = CntW'(DATA_BITS - 1);
  localparam logic [CntW-1:0] LastStop = CntW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                 state_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [CntW-1:0]        cnt_q;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
`endif

  // Frame sequencer: state, shift register, bit counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      cnt_q       <= '0;
      txd         <= 1'b1;
      txReady     <= 1'b1;
      countEnable <= 1'b0;
      txDone      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      // txDone is a single-cycle strobe; only the final stop pulse raises it.
      txDone <= 1'b0;
      unique case (state_q)
        // Idle line; bpsClk is ignored here, including on the handshake edge.
        StIdle: begin
          if (txValid && txReady) begin
            shift_q     <= txData;
            cnt_q       <= '0;
            state_q     <= StStart;
            txReady     <= 1'b0;
            txd         <= 1'b0;
            countEnable <= 1'b1;
`ifdef UART_TX_PARITY_EN
            // Parity comes from the latched word, so later txData changes cannot disturb it.
            parity_q    <= ^txData;
`endif
          end
        end

        StStart: begin
          if (bpsClk) begin
            txd     <= shift_q[0];
            state_q <= StData;
          end
        end

        // shift_q[0] is always the bit on the line; shift_q[1] is the one that follows.
        StData: begin
          if (bpsClk) begin
            shift_q <= shift_q >> 1;
            if (cnt_q == LastData) begin
              cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= StParity;
              txd     <= parity_q;
`else
              state_q <= StStop;
              txd     <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
              txd   <= shift_q[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bpsClk) begin
            state_q <= StStop;
            txd     <= 1'b1;
            cnt_q   <= '0;
          end
        end
`endif

        // Dropping countEnable here gives the baud generator at least one idle cycle.
        StStop: begin
          if (bpsClk) begin
            if (cnt_q == LastStop) begin
              state_q     <= StIdle;
              cnt_q       <= '0;
              txDone      <= 1'b1;
              txReady     <= 1'b1;
              countEnable <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q     <= StIdle;
          txd         <= 1'b1;
          txReady     <= 1'b1;
          countEnable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: dut0 uses one stop bit, dut1 uses two stop bits.
// The bench drives bpsClk itself, pulsing it every 16 clk, and checks txd once per bit period.
// Inputs change only on the falling edge, which is also when outputs are sampled.

module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif
  localparam int Period = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0][7:0] tx_data;
  logic [1:0] tx_valid;
  logic [1:0] bps;
  logic ready0, ready1, ce0, ce1, txd0, txd1, done0, done1;
  logic [1:0] tx_ready, ce, txd, tx_done;

  assign tx_ready = {ready1, ready0};
  assign ce       = {ce1, ce0};
  assign txd      = {txd1, txd0};
  assign tx_done  = {done1, done0};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1)) u_dut0 (
    .clk         (clk),
    .reset       (rst_n),
    .txData      (tx_data[0]),
    .txValid     (tx_valid[0]),
    .txReady     (ready0),
    .bpsClk      (bps[0]),
    .countEnable (ce0),
    .txd         (txd0),
    .txDone      (done0)
  );

  uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(2)) u_dut1 (
    .clk         (clk),
    .reset       (rst_n),
    .txData      (tx_data[1]),
    .txValid     (tx_valid[1]),
    .txReady     (ready1),
    .bpsClk      (bps[1]),
    .countEnable (ce1),
    .txd         (txd1),
    .txDone      (done1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level for bit period b of a frame carrying w.
  function automatic logic exp_bit(input int b, input logic [7:0] w);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (Par == 1 && b == 9) return ^w;
    return 1'b1;
  endfunction

  function automatic int frame_len(input int i);
    return 1 + 8 + Par + (i + 1);
  endfunction

  // Called at a falling edge with the framer idle; the handshake edge follows.
  task automatic handshake(input int i, input logic [7:0] w, input logic pulse);
    check_eq($sformatf("hs%0d_ready_before w=%0h", i, w), 32'(tx_ready[i]), 32'd1);
    tx_data[i]  = w;
    tx_valid[i] = 1'b1;
    bps[i]      = pulse;
    @(negedge clk);
    bps[i] = 1'b0;
    check_eq($sformatf("hs%0d_ready w=%0h", i, w), 32'(tx_ready[i]), 32'd0);
    check_eq($sformatf("hs%0d_txd w=%0h", i, w), 32'(txd[i]), 32'd0);
    check_eq($sformatf("hs%0d_ce w=%0h", i, w), 32'(ce[i]), 32'd1);
  endtask

  // Handshake that should occur at the first edge after txDone, with txValid held high.
  task automatic accept_check(input int i);
    @(negedge clk);
    check_eq($sformatf("b2b%0d_ready", i), 32'(tx_ready[i]), 32'd0);
    check_eq($sformatf("b2b%0d_txd", i), 32'(txd[i]), 32'd0);
    check_eq($sformatf("b2b%0d_ce", i), 32'(ce[i]), 32'd1);
    check_eq($sformatf("b2b%0d_done", i), 32'(tx_done[i]), 32'd0);
  endtask

  task automatic idle_check(input int i);
    @(negedge clk);
    check_eq($sformatf("idle%0d_done", i), 32'(tx_done[i]), 32'd0);
    check_eq($sformatf("idle%0d_ready", i), 32'(tx_ready[i]), 32'd1);
    check_eq($sformatf("idle%0d_txd", i), 32'(txd[i]), 32'd1);
    check_eq($sformatf("idle%0d_ce", i), 32'(ce[i]), 32'd0);
  endtask

  // Runs one frame from the falling edge after the handshake. stall_b withholds bpsClk for
  // stall_len extra cycles mid-period; abort_b pulses reset low mid-period and returns.
  task automatic expect_frame(input int i, input logic [7:0] w, input int stall_b,
                              input int stall_len, input int abort_b);
    for (int b = 0; b < frame_len(i); b++) begin
      for (int c = 0; c < Period; c++) begin
        if (c == 0 || c == Period - 1) begin
          check_eq($sformatf("f%0d w=%0h bit%0d c%0d txd", i, w, b, c), 32'(txd[i]),
                   32'(exp_bit(b, w)));
          check_eq($sformatf("f%0d w=%0h bit%0d ce", i, w, b), 32'(ce[i]), 32'd1);
          check_eq($sformatf("f%0d w=%0h bit%0d done", i, w, b), 32'(tx_done[i]), 32'd0);
        end
        if (b == abort_b && c == 7) begin
          rst_n  = 1'b0;
          bps[i] = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          check_eq($sformatf("abort%0d_txd", i), 32'(txd[i]), 32'd1);
          check_eq($sformatf("abort%0d_ce", i), 32'(ce[i]), 32'd0);
          check_eq($sformatf("abort%0d_ready", i), 32'(tx_ready[i]), 32'd1);
          check_eq($sformatf("abort%0d_done", i), 32'(tx_done[i]), 32'd0);
          return;
        end
        if (b == stall_b && c == 7) begin
          for (int s = 0; s < stall_len; s++) begin
            bps[i] = 1'b0;
            @(negedge clk);
            check_eq($sformatf("stall%0d bit%0d s%0d txd", i, b, s), 32'(txd[i]),
                     32'(exp_bit(b, w)));
            check_eq($sformatf("stall%0d bit%0d s%0d ce", i, b, s), 32'(ce[i]), 32'd1);
          end
        end
        bps[i] = (c == Period - 1);
        @(negedge clk);
      end
    end
    bps[i] = 1'b0;
    check_eq($sformatf("end%0d w=%0h done", i, w), 32'(tx_done[i]), 32'd1);
    check_eq($sformatf("end%0d w=%0h ready", i, w), 32'(tx_ready[i]), 32'd1);
    check_eq($sformatf("end%0d w=%0h ce", i, w), 32'(ce[i]), 32'd0);
    check_eq($sformatf("end%0d w=%0h txd", i, w), 32'(txd[i]), 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_data  = '0;
    tx_valid = '0;
    bps      = '0;

    // Reset state on both instances.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst%0d_txd", i), 32'(txd[i]), 32'd1);
      check_eq($sformatf("rst%0d_ready", i), 32'(tx_ready[i]), 32'd1);
      check_eq($sformatf("rst%0d_ce", i), 32'(ce[i]), 32'd0);
      check_eq($sformatf("rst%0d_done", i), 32'(tx_done[i]), 32'd0);
    end
    rst_n = 1'b1;
    idle_check(0);

    // Single frame, 0x55.
    handshake(0, 8'h55, 1'b0);
    tx_valid[0] = 1'b0;
    expect_frame(0, 8'h55, -1, 0, -1);
    idle_check(0);

    // Parity cases: 0xA3 has four ones, 0x07 has three.
    handshake(0, 8'hA3, 1'b0);
    tx_valid[0] = 1'b0;
    expect_frame(0, 8'hA3, -1, 0, -1);
    idle_check(0);
    handshake(0, 8'h07, 1'b0);
    tx_valid[0] = 1'b0;
    expect_frame(0, 8'h07, -1, 0, -1);
    idle_check(0);

    // Two stop bits, back-to-back with txValid held high.
    handshake(1, 8'h00, 1'b0);
    tx_data[1] = 8'hFF;
    expect_frame(1, 8'h00, -1, 0, -1);
    accept_check(1);
    tx_valid[1] = 1'b0;
    expect_frame(1, 8'hFF, -1, 0, -1);
    idle_check(1);

    // Reset during data bit 3 (bit period 4); nothing may resume afterwards.
    handshake(0, 8'h3C, 1'b0);
    tx_valid[0] = 1'b0;
    expect_frame(0, 8'h3C, -1, 0, 4);
    for (int c = 0; c < 3 * Period; c++) begin
      bps[0] = ((c % Period) == Period - 1);
      @(negedge clk);
      check_eq($sformatf("postrst c%0d done", c), 32'(tx_done[0]), 32'd0);
      check_eq($sformatf("postrst c%0d txd", c), 32'(txd[0]), 32'd1);
      check_eq($sformatf("postrst c%0d ce", c), 32'(ce[0]), 32'd0);
    end
    bps[0] = 1'b0;
    @(negedge clk);
    handshake(0, 8'h81, 1'b0);
    tx_valid[0] = 1'b0;
    expect_frame(0, 8'h81, -1, 0, -1);
    idle_check(0);

    // bpsClk on the handshake edge, and txData changed mid-frame with txValid high.
    handshake(0, 8'h5A, 1'b1);
    tx_data[0] = 8'hEE;
    expect_frame(0, 8'h5A, -1, 0, -1);
    accept_check(0);
    tx_valid[0] = 1'b0;
    expect_frame(0, 8'hEE, -1, 0, -1);
    idle_check(0);

    // bpsClk withheld for 200 clk during data bit 2.
    handshake(0, 8'hC6, 1'b0);
    tx_valid[0] = 1'b0;
    expect_frame(0, 8'hC6, 3, 200, -1);
    idle_check(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Transmit framer that sits directly upstream of the baud-rate clock generator and consumes its bpsClk pulse stream.
- Accepts one data word per valid/ready handshake and asserts countEnable for the duration of the frame.
- Advances one bit per bpsClk pulse and serialises start, data (LSB first), optional parity and stop bits onto txd.
- txd is the serial-port line output of the transmit path.

Parameters:
- DATA_BITS, 8: data word width, legal range 5..9.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- txData  input  DATA_BITS  word to transmit; sampled only on handshake.
- txValid  input  1  txData valid.
- txReady  output  1  framer idle, can accept a word.
- bpsClk  input  1  one-clk-wide pulse, once per bit period, from the baud generator.
- countEnable  output  1  enables the baud generator; high for the whole frame.
- txd  output  1  serial line; idle high.
- txDone  output  1  one-cycle pulse when the final stop bit period ends.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a clk edge): state IDLE, txd=1, txReady=1, countEnable=0, txDone=0, bit counter=0, shift register=0.
- Reset has priority over every other event, including mid-frame. txd returns to 1 and countEnable to 0 at that same edge. No partial frame resumes after reset release.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - txd=1, countEnable=0; bpsClk ignored.
  - Handshake completes on an edge with txValid && txReady. At that edge: latch txData, clear the bit counter, go to START.
  - At the same edge, drive txReady=0, txd=0 and countEnable=1. The start bit begins one cycle after the handshake edge.
- START: on a bpsClk pulse, txd=shift[0] and go to DATA.
- DATA:
  - Each bpsClk pulse shifts right and increments the counter; txd shows the next bit.
  - After the pulse ending bit DATA_BITS-1, go to PARITY (if compiled in) or STOP. txd=parity or 1 accordingly.
- STOP:
  - txd=1; counts STOP_BITS bpsClk pulses.
  - On the final pulse: go to IDLE, txDone=1 for exactly one cycle, txReady=1, countEnable=0, all at the same edge.
- Cycles without a bpsClk pulse hold state and txd unchanged; there is no timeout.
- countEnable is low for at least one full cycle between frames (IDLE), so the baud generator restarts its count for every frame.
- Back-to-back frames: if txValid is held high, the next word is accepted on the first edge after returning to IDLE.
  - Minimum inter-frame gap is one clk cycle of idle-high beyond the stop bit(s).
- txData/txValid changes while txReady=0 have no effect on the frame in flight.
- A bpsClk pulse on the handshake edge is ignored; the first counted pulse ends the start bit.
- Frame length in bit periods: 1 + DATA_BITS + [1 if parity] + STOP_BITS.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state is inserted after the last data bit, lasting one bit period.
  - txd carries even parity, i.e. the XOR of the latched data bits, so the total count of ones over data+parity is even.
  - The parity bit is computed from the word latched at handshake.
- Undefined: the PARITY state and its logic are absent; DATA goes directly to STOP.

Test Plan:
1. Defaults, no macro; send 0x55; bench pulses bpsClk every 16 clk.
   - txd sequence per bit period: 0,1,0,1,0,1,0,1,0,1.
   - countEnable high for exactly 10 bpsClk periods.
   - txDone pulses once; txReady returns 1 on the same edge.
2. UART_TX_PARITY_EN defined; send 0xA3 then 0x07.
   - Parity bit 0 for 0xA3 (four ones) and 1 for 0x07 (three ones).
   - Frame is 11 bit periods.
3. STOP_BITS=2; txValid held high with 0x00 then 0xFF.
   - Two stop-bit periods of txd=1 per frame.
   - Second handshake occurs exactly one clk after the first txDone.
   - countEnable is low for exactly that one cycle.
4. Reset pulled low for one cycle during data bit 3 of 0x3C.
   - Next edge: txd=1, countEnable=0, txReady=1.
   - No txDone; a fresh 0x81 afterwards frames correctly.
5. Stimulus hazards: bpsClk asserted on the handshake cycle; txData changed to 0xEE mid-frame with txValid high.
   - The handshake-cycle pulse is not counted.
   - Transmitted word stays the originally latched 0x5A.
   - 0xEE is sent only as the next frame.
6. bpsClk withheld for 200 clk during DATA.
   - State and txd hold steadily.
   - The frame resumes on the next pulse with correct bit order.
